// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL control and status signals of the lock sequencer
interface pll_lock_sequencer_if #(
   parameter int MAX_RETRIES = 3
);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   logic          pll_locked;
   logic          relock_req;
   logic          pll_rst;
   logic          sys_rst;
   logic          ready;
   logic          fail;
   logic          lock_lost;
   logic [RW-1:0] retry_cnt;

   modport master (
      input  pll_locked, relock_req,
      output pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt
   );

   modport slave (
      output pll_locked, relock_req,
      input  pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock qualification and system reset release
module pll_lock_sequencer #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRIES         = 3,
   parameter int SYNC_STAGES         = 2
) (
   input  logic                 refclk,
   input  logic                 rst_n,
   pll_lock_sequencer_if.master bus
);
   localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
   localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RW        = $clog2(MAX_RETRIES + 1);

   localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      RST_PLL,
      WAIT_LOCK,
      STABILIZE,
      RUN,
      FAIL
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [RW-1:0]          retry_q, retry_d, retry_inc;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   logic                   lock_lost_q, lock_lost_d;
   logic                   pll_rst_q, sys_rst_q, ready_q, fail_q;

   assign locked_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         state_q     <= RST_PLL;
         cnt_q       <= '0;
         retry_q     <= '0;
         lock_lost_q <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         lock_lost_q <= lock_lost_d;
         // Outputs follow the next state so they change on the same edge as the state.
         pll_rst_q   <= (state_d == RST_PLL);
         ready_q     <= (state_d == RUN);
         sys_rst_q   <= (state_d != RUN);
         fail_q      <= (state_d == FAIL);
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      retry_d     = retry_q;
      lock_lost_d = 1'b0;
      retry_inc   = retry_q + RW'(1);
      case (state_q)
         RST_PLL: begin
            if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            else                   cnt_d   = cnt_q + CW'(1);
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d = STABILIZE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RW'(MAX_RETRIES)) ? FAIL : RST_PLL;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STABILIZE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            if (!locked_s) begin
               lock_lost_d = 1'b1;
               state_d     = RST_PLL;
            end
         end
         FAIL:    state_d = FAIL;
         default: state_d = RST_PLL;
      endcase
      // A relock request overrides every state but still lets a coincident lock_lost pulse out.
      if (bus.relock_req) begin
         state_d = RST_PLL;
         retry_d = '0;
      end
      if ((state_d != state_q) || bus.relock_req) cnt_d = '0;
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.sys_rst   = sys_rst_q;
   assign bus.ready     = ready_q;
   assign bus.fail      = fail_q;
   assign bus.lock_lost = lock_lost_q;
   assign bus.retry_cnt = retry_q;
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the PLL's reset input and its lock status on the fabric reference clock.
- Pulses the PLL reset, then waits for lock and qualifies it as stable.
- Releases a downstream system reset only after lock is qualified.
- Re-runs the sequence on loss of lock or on request, with bounded retries and a sticky failure state.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per attempt (min 1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles needed to qualify lock (min 1).
- LOCK_TIMEOUT_CYCLES, 1000000: refclk cycles to wait for first lock per attempt (20 ms at 50 MHz).
- MAX_RETRIES, 3: failed attempts before entering FAIL (min 1).
- SYNC_STAGES, 2: flops in the pll_locked synchronizer (min 2).

Ports:
- refclk  in  1  free-running reference clock; all logic runs on it.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  raw PLL lock flag, asynchronous to refclk.
- relock_req  in  1  single-cycle request to restart the sequence (e.g. after reconfiguration).
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst  out  1  active-high reset for logic clocked by the PLL output; consumers re-synchronize it.
- ready  out  1  lock qualified; PLL output usable.
- fail  out  1  retries exhausted; sticky.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  failed attempts in the current sequence.

Behaviour:
- Reset values (rst_n low, asserted asynchronously): pll_rst=1, sys_rst=1, ready=0, fail=0, lock_lost=0, retry_cnt=0, state=RST_PLL, counter=0, synchronizer=0.
- locked_s is pll_locked after SYNC_STAGES flops. All decisions use locked_s only.
- Outputs are registered. sys_rst is the registered inverse of ready. sys_rst=1 and ready=0 in every state except RUN.
- RST_PLL:
  - pll_rst=1.
  - The counter counts 0..RST_PULSE_CYCLES-1. pll_rst is high for exactly RST_PULSE_CYCLES cycles.
  - Then go to WAIT_LOCK with counter=0.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABILIZE with counter=0.
  - Otherwise, at counter==LOCK_TIMEOUT_CYCLES-1, increment retry_cnt. If the new value equals MAX_RETRIES, go to FAIL; else go to RST_PLL.
- STABILIZE:
  - pll_rst=0.
  - Any locked_s=0 cycle: go to WAIT_LOCK with counter=0. The timeout restarts; retry_cnt is unchanged.
  - After LOCK_STABLE_CYCLES consecutive locked_s=1 cycles, go to RUN. retry_cnt clears.
- RUN:
  - ready=1 and sys_rst=0, registered on the same edge the state enters RUN.
  - locked_s=0: lock_lost pulses for 1 cycle. Go to RST_PLL; ready drops and sys_rst rises on that same edge.
- FAIL:
  - pll_rst=0, fail=1, sys_rst=1.
  - Held until relock_req or rst_n.
- relock_req (any state, highest priority):
  - Go to RST_PLL with counter=0. retry_cnt clears and fail clears.
  - In RST_PLL it restarts the pulse count.
  - Simultaneous with lock drop in RUN: the relock path is taken and lock_lost still pulses.
- Counter: one shared counter, width $clog2 of the largest parameter. It never wraps; it clears on every state change.
- A PLL glitch shorter than SYNC_STAGES cycles may be missed. This is accepted.

Test Plan:
Use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2 unless stated.
- Nominal bring-up: release rst_n; raise pll_locked 10 cycles after pll_rst falls and hold it -> pll_rst high exactly 4 cycles; ready=1 and sys_rst=0 exactly 2+8 cycles after locked rises; retry_cnt=0.
- Timeout and FAIL: hold pll_locked=0 -> two pll_rst pulses of 4 cycles, 32-cycle waits, retry_cnt 1 then 2; fail=1 after the second timeout; pll_rst stays 0; sys_rst=1; no further pulses over 1000 cycles.
- Unstable lock: toggle locked high for 5 cycles, low for 1, repeatedly -> never reaches RUN; returns to WAIT_LOCK each time; retry_cnt unchanged until a 32-cycle no-lock window elapses.
- Lock loss in RUN: drop pll_locked -> lock_lost pulses 1 cycle, SYNC_STAGES cycles after the drop; same edge ready=0, sys_rst=1; new 4-cycle pll_rst pulse follows; re-lock returns to RUN.
- relock_req from FAIL and in RUN: pulse relock_req -> fail=0, retry_cnt=0, pll_rst high 4 cycles; assert it together with a lock drop in RUN -> exactly one pll_rst pulse and one lock_lost pulse.
- Async reset mid-STABILIZE: pull rst_n low -> pll_rst=1, sys_rst=1, ready=0 immediately without a clock edge; on release the full sequence restarts from RST_PLL.
